prog_loader: RTL and testbench

- Upstream program-load stage for proc.
- Accepts a stream of 32-bit words from the host or bus side and packs every four words into one 128-bit command.
- Writes each command into proc's command memory through proc's write_prog_enable/cmd_addr/cmd_data inputs, with an auto-incrementing address.
- Holds proc in reset while a load is in progress and releases it when the load completes successfully.

---
 rtl/prog_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Packs a stream of WORD_WIDTH words MSB-first into CMD_WIDTH
//               commands and writes them into proc's command memory, holding
//               proc in reset until the load completes. Optional macro
//               PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int CMD_WIDTH  = 128,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  word_last,
    output logic                  write_prog_enable,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [CMD_WIDTH-1:0]  cmd_data,
    output logic                  proc_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic                  checksum_err
`endif
);

    localparam int WORDS_PER_CMD = CMD_WIDTH / WORD_WIDTH;
    localparam int SLOT_W        = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;
`endif

    state_t                  r_state, w_state;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [SLOT_W-1:0]       r_slot, w_slot;
    logic [CMD_WIDTH-1:0]    r_asm, w_asm;
    logic                    r_last, w_last;
    logic                    r_wpe, w_wpe;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr, w_cmd_addr;
    logic [CMD_WIDTH-1:0]    r_cmd_data, w_cmd_data;
    logic                    r_proc_reset, w_proc_reset;
    logic                    r_busy, w_busy;
    logic                    r_done, w_done;
    logic                    r_overflow, w_overflow;
    logic [CMD_WIDTH-1:0]    w_asm_ins;
    logic                    w_xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]   r_xor, w_xor;
    logic                    r_csum_err, w_csum_err;
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
    assign word_ready = (r_state == S_COLLECT) || (r_state == S_CHECK);
`else
    assign word_ready = (r_state == S_COLLECT);
`endif
    assign w_xfer = word_valid & word_ready;

    // Assembly register with the incoming word dropped into the current slot
    always_comb begin
        w_asm_ins = r_asm;
        for (int k = 0; k < WORDS_PER_CMD; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_asm_ins[CMD_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = word_in;
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_addr       = r_addr;
        w_slot       = r_slot;
        w_asm        = r_asm;
        w_last       = r_last;
        w_wpe        = 1'b0;
        w_cmd_addr   = r_cmd_addr;
        w_cmd_data   = r_cmd_data;
        w_proc_reset = r_proc_reset;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_overflow   = r_overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_xor        = r_xor;
        w_csum_err   = r_csum_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state      = S_COLLECT;
                    w_busy       = 1'b1;
                    w_proc_reset = 1'b1;
                    w_overflow   = 1'b0;
                    w_addr       = '0;
                    w_slot       = '0;
                    w_asm        = '0;
                    w_last       = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_xor        = '0;
                    w_csum_err   = 1'b0;
`endif
                end
            end
            S_COLLECT: begin
                if (w_xfer) begin
                    w_asm = w_asm_ins;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_xor = r_xor ^ word_in;
`endif
                    // Unfilled low slots stay zero from the clear on entry
                    if (word_last || (r_slot == SLOT_W'(WORDS_PER_CMD-1))) begin
                        w_state    = S_WRITE;
                        w_last     = word_last;
                        w_wpe      = 1'b1;
                        w_cmd_addr = r_addr;
                        w_cmd_data = w_asm_ins;
                    end else begin
                        w_slot = r_slot + SLOT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (r_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_state      = S_CHECK;
`else
                    w_state      = S_DONE;
                    w_done       = 1'b1;
                    w_proc_reset = 1'b0;
                    w_busy       = 1'b0;
`endif
                end else if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                    // Memory full: abort without wrapping, proc stays parked
                    w_state    = S_IDLE;
                    w_overflow = 1'b1;
                    w_busy     = 1'b0;
                end else begin
                    w_state = S_COLLECT;
                    w_addr  = r_addr + ADDR_WIDTH'(1);
                    w_slot  = '0;
                    w_asm   = '0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    w_busy = 1'b0;
                    if (word_in == r_xor) begin
                        w_state      = S_DONE;
                        w_done       = 1'b1;
                        w_proc_reset = 1'b0;
                    end else begin
                        w_state    = S_IDLE;
                        w_csum_err = 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_slot       <= '0;
            r_asm        <= '0;
            r_last       <= 1'b0;
            r_wpe        <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_data   <= '0;
            r_proc_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor        <= '0;
            r_csum_err   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_addr       <= w_addr;
            r_slot       <= w_slot;
            r_asm        <= w_asm;
            r_last       <= w_last;
            r_wpe        <= w_wpe;
            r_cmd_addr   <= w_cmd_addr;
            r_cmd_data   <= w_cmd_data;
            r_proc_reset <= w_proc_reset;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_overflow   <= w_overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor        <= w_xor;
            r_csum_err   <= w_csum_err;
`endif
        end
    end

    assign write_prog_enable = r_wpe;
    assign cmd_addr          = r_cmd_addr;
    assign cmd_data          = r_cmd_data;
    assign proc_reset        = r_proc_reset;
    assign busy              = r_busy;
    assign done              = r_done;
    assign overflow          = r_overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign checksum_err      = r_csum_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomized self-checking bench for prog_loader against a
//               word-list packing model; honours PROG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, word_valid, word_last;
    logic [31:0]  word_in;
    logic         word_ready, write_prog_enable, proc_reset, busy, done, overflow;
    logic [7:0]   cmd_addr;
    logic [127:0] cmd_data;

    logic         s_start, s_word_valid, s_word_last;
    logic [31:0]  s_word_in;
    logic         s_word_ready, s_wpe, s_proc_reset, s_busy, s_done, s_overflow;
    logic [1:0]   s_cmd_addr;
    logic [127:0] s_cmd_data;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic         checksum_err, s_checksum_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   got_addr[$];
    logic [127:0] got_data[$];
    int           done_cnt = 0;
    logic [1:0]   s_got_addr[$];
    logic [127:0] s_got_data[$];
    int           s_done_cnt = 0;
    logic [31:0]  prog_q[$];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
        .write_prog_enable(write_prog_enable), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .proc_reset(proc_reset), .busy(busy), .done(done), .overflow(overflow)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .checksum_err(checksum_err)
`endif
    );

    prog_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .word_in(s_word_in),
        .word_valid(s_word_valid), .word_ready(s_word_ready), .word_last(s_word_last),
        .write_prog_enable(s_wpe), .cmd_addr(s_cmd_addr), .cmd_data(s_cmd_data),
        .proc_reset(s_proc_reset), .busy(s_busy), .done(s_done), .overflow(s_overflow)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .checksum_err(s_checksum_err)
`endif
    );

    always @(negedge clk) begin
        if (write_prog_enable) begin
            got_addr.push_back(cmd_addr);
            got_data.push_back(cmd_data);
        end
        if (done) done_cnt++;
        if (s_wpe) begin
            s_got_addr.push_back(s_cmd_addr);
            s_got_data.push_back(s_cmd_data);
        end
        if (s_done) s_done_cnt++;
    end

    // Reference: word i of the program lands in command i/4, 32-bit lane i%4 from the top
    function automatic logic [127:0] model_cmd(input int c);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 4; j++)
            if (c * 4 + j < prog_q.size())
                v = v | ({96'd0, prog_q[c*4+j]} << (32 * (3 - j)));
        return v;
    endfunction

    function automatic logic [31:0] model_xor();
        logic [31:0] x;
        x = '0;
        foreach (prog_q[i]) x = x ^ prog_q[i];
        return x;
    endfunction

    task automatic send_word(input logic [31:0] w, input logic last, output bit got);
        got = 1'b0;
        @(negedge clk);
        word_valid = 1'b1; word_in = w; word_last = last;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (word_ready) begin
                @(posedge clk);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_program(input bit mid_start, input int gap_max, input bit bad_csum,
                                output bit ok, output logic st_busy, output logic st_prst,
                                output logic lat_wpe, output logic [7:0] lat_addr,
                                output logic lat_done, output logic lat_prst);
        bit got;
        int n;
        n  = prog_q.size();
        ok = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1; st_busy = busy; st_prst = proc_reset;
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == n / 2) begin
                @(negedge clk); word_valid = 1'b0; start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk); word_valid = 1'b0;
            end
            send_word(prog_q[i], (i == n - 1), got);
            if (!got) begin ok = 1'b0; break; end
        end
        @(negedge clk);
        word_valid = 1'b0; word_last = 1'b0;
        lat_wpe = write_prog_enable; lat_addr = cmd_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(bad_csum ? (model_xor() ^ 32'h1) : model_xor(), 1'b0, got);
        if (!got) ok = 1'b0;
        @(negedge clk);
        word_valid = 1'b0;
`else
        if (bad_csum) ok = 1'b0;
        @(negedge clk);
`endif
        lat_done = done; lat_prst = proc_reset;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; word_valid = 0; word_last = 0; word_in = 0;
        s_start = 0; s_word_valid = 0; s_word_last = 0; s_word_in = 0;
        #23;
        total++; if (proc_reset !== 1'b1) begin bad++; $display("FAIL reset_proc_reset: got %b want 1", proc_reset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (write_prog_enable !== 1'b0) begin bad++; $display("FAIL reset_wpe: got %b want 0", write_prog_enable); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (word_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", word_ready); end
        total++; if (cmd_addr !== 8'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", cmd_addr); end
        total++; if (cmd_data !== 128'd0) begin bad++; $display("FAIL reset_data: got %h want 0", cmd_data); end
        total++; if (s_proc_reset !== 1'b1) begin bad++; $display("FAIL reset_small_proc_reset: got %b want 1", s_proc_reset); end
`ifdef PROG_LOADER_CHECKSUM_EN
        total++; if (checksum_err !== 1'b0) begin bad++; $display("FAIL reset_csum_err: got %b want 0", checksum_err); end
`endif
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (proc_reset !== 1'b1) begin bad++; $display("FAIL parked_proc_reset: got %b want 1", proc_reset); end
    endtask

    task automatic test_directed();
        bit ok; logic sb, sp, lw, ld, lp; logic [7:0] la; int base, d0;
        prog_q = '{32'h18000000, 32'h0000000C, 32'h0, 32'h0,
                   32'h18000000, 32'h00000005, 32'h0, 32'h00010000};
        base = got_addr.size(); d0 = done_cnt;
        load_program(1'b0, 0, 1'b0, ok, sb, sp, lw, la, ld, lp);
        total++; if (!ok) begin bad++; $display("FAIL dir_handshake: got stall want transfers"); end
        total++; if (sb !== 1'b1 || sp !== 1'b1) begin bad++; $display("FAIL dir_start: got busy=%b proc_reset=%b want 1 1", sb, sp); end
        total++; if (lw !== 1'b1 || la !== 8'd1) begin bad++; $display("FAIL dir_write_latency: got wpe=%b addr=%h want 1 01", lw, la); end
        total++; if (ld !== 1'b1 || lp !== 1'b0) begin bad++; $display("FAIL dir_done_latency: got done=%b proc_reset=%b want 1 0", ld, lp); end
        total++; if (got_addr.size() - base != 2) begin bad++; $display("FAIL dir_write_count: got %0d want 2", got_addr.size() - base); end
        else begin
            total++; if (got_addr[base] !== 8'd0 || got_data[base] !== 128'h18000000_0000000C_00000000_00000000)
                begin bad++; $display("FAIL dir_cmd0: got %h:%h want 00:180000000000000c0000000000000000", got_addr[base], got_data[base]); end
            total++; if (got_addr[base+1] !== 8'd1 || got_data[base+1] !== 128'h18000000_00000005_00000000_00010000)
                begin bad++; $display("FAIL dir_cmd1: got %h:%h want 01:18000000000000050000000000010000", got_addr[base+1], got_data[base+1]); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL dir_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (proc_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dir_released: got proc_reset=%b busy=%b want 0 0", proc_reset, busy); end
    endtask

    task automatic test_partial();
        bit ok; logic sb, sp, lw, ld, lp; logic [7:0] la; int base;
        prog_q = '{$urandom, $urandom, $urandom};
        base = got_addr.size();
        load_program(1'b0, 0, 1'b0, ok, sb, sp, lw, la, ld, lp);
        total++; if (!ok || lw !== 1'b1 || la !== 8'd0) begin bad++; $display("FAIL part_write: got ok=%b wpe=%b addr=%h want 1 1 00", ok, lw, la); end
        total++; if (ld !== 1'b1) begin bad++; $display("FAIL part_done: got %b want 1", ld); end
        total++; if (got_addr.size() - base != 1) begin bad++; $display("FAIL part_count: got %0d want 1", got_addr.size() - base); end
        else begin
            total++; if (got_data[base] !== model_cmd(0)) begin bad++; $display("FAIL part_data: got %h want %h", got_data[base], model_cmd(0)); end
        end
    endtask

    task automatic test_random_gaps();
        bit ok; logic sb, sp, lw, ld, lp; logic [7:0] la; int base, d0, n, nc;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 4 : int'($urandom_range(1, 14));
            nc = (n + 3) / 4;
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back($urandom);
            base = got_addr.size(); d0 = done_cnt;
            load_program(1'b0, 3, 1'b0, ok, sb, sp, lw, la, ld, lp);
            total++; if (!ok || ld !== 1'b1) begin bad++; $display("FAIL gap_done[%0d]: got ok=%b done=%b want 1 1", it, ok, ld); end
            total++; if (la !== 8'(nc - 1)) begin bad++; $display("FAIL gap_last_addr[%0d]: got %h want %h", it, la, 8'(nc - 1)); end
            total++; if (got_addr.size() - base != nc) begin bad++; $display("FAIL gap_count[%0d]: got %0d want %0d", it, got_addr.size() - base, nc); end
            else for (int c = 0; c < nc; c++) begin
                total++;
                if (got_addr[base+c] !== 8'(c) || got_data[base+c] !== model_cmd(c)) begin
                    bad++; $display("FAIL gap_cmd[%0d.%0d]: got %h:%h want %h:%h", it, c, got_addr[base+c], got_data[base+c], 8'(c), model_cmd(c));
                end
            end
            total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL gap_done_count[%0d]: got %0d want 1", it, done_cnt - d0); end
        end
    endtask

    task automatic test_start_mid();
        bit ok; logic sb, sp, lw, ld, lp; logic [7:0] la; int base;
        prog_q.delete();
        for (int i = 0; i < 10; i++) prog_q.push_back($urandom);
        base = got_addr.size();
        load_program(1'b1, 1, 1'b0, ok, sb, sp, lw, la, ld, lp);
        total++; if (!ok || ld !== 1'b1) begin bad++; $display("FAIL mid_start_done: got ok=%b done=%b want 1 1", ok, ld); end
        total++; if (got_addr.size() - base != 3) begin bad++; $display("FAIL mid_start_count: got %0d want 3", got_addr.size() - base); end
        else for (int c = 0; c < 3; c++) begin
            total++;
            if (got_addr[base+c] !== 8'(c) || got_data[base+c] !== model_cmd(c)) begin
                bad++; $display("FAIL mid_start_cmd[%0d]: got %h:%h want %h:%h", c, got_addr[base+c], got_data[base+c], 8'(c), model_cmd(c));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got; int base, d0;
        base = got_addr.size(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_word($urandom, 1'b0, got);
        send_word($urandom, 1'b0, got);
        @(negedge clk); word_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++; if (proc_reset !== 1'b1 || busy !== 1'b0 || word_ready !== 1'b0)
            begin bad++; $display("FAIL mid_reset_now: got proc_reset=%b busy=%b ready=%b want 1 0 0", proc_reset, busy, word_ready); end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (got_addr.size() != base || done_cnt != d0)
            begin bad++; $display("FAIL mid_reset_nowrite: got writes=%0d dones=%0d want 0 0", got_addr.size() - base, done_cnt - d0); end
    endtask

    task automatic test_overflow();
        bit got; int base, sd0, acc;
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back($urandom);
        base = s_got_addr.size(); sd0 = s_done_cnt;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_word_valid = 1'b1; s_word_in = prog_q[i]; s_word_last = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                #1;
                if (s_word_ready) begin @(posedge clk); got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin
                total++; bad++; $display("FAIL ovf_handshake: got stall at word %0d want transfer", i);
                break;
            end
        end
        @(negedge clk); s_word_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (s_overflow !== 1'b1 || s_busy !== 1'b0 || s_proc_reset !== 1'b1)
            begin bad++; $display("FAIL ovf_flags: got ovf=%b busy=%b proc_reset=%b want 1 0 1", s_overflow, s_busy, s_proc_reset); end
`ifdef PROG_LOADER_CHECKSUM_EN
        total++; if (s_checksum_err !== 1'b0) begin bad++; $display("FAIL ovf_csum_err: got %b want 0", s_checksum_err); end
`endif
        s_word_valid = 1'b1; s_word_in = $urandom; acc = 0;
        repeat (8) begin @(negedge clk); #1; if (s_word_ready) acc++; end
        s_word_valid = 1'b0;
        total++; if (acc != 0) begin bad++; $display("FAIL ovf_no_accept: got ready %0d cycles want 0", acc); end
        total++; if (s_got_addr.size() - base != 4) begin bad++; $display("FAIL ovf_write_count: got %0d want 4", s_got_addr.size() - base); end
        else for (int c = 0; c < 4; c++) begin
            total++;
            if (s_got_addr[base+c] !== 2'(c) || s_got_data[base+c] !== model_cmd(c)) begin
                bad++; $display("FAIL ovf_cmd[%0d]: got %h:%h want %h:%h", c, s_got_addr[base+c], s_got_data[base+c], 2'(c), model_cmd(c));
            end
        end
        total++; if (s_done_cnt != sd0) begin bad++; $display("FAIL ovf_no_done: got %0d want 0", s_done_cnt - sd0); end
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        #1;
        total++; if (s_overflow !== 1'b0 || s_busy !== 1'b1) begin bad++; $display("FAIL ovf_clear_on_start: got ovf=%b busy=%b want 0 1", s_overflow, s_busy); end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok; logic sb, sp, lw, ld, lp; logic [7:0] la; int d0;
        prog_q = '{$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        load_program(1'b0, 1, 1'b0, ok, sb, sp, lw, la, ld, lp);
        total++; if (!ok || ld !== 1'b1 || lp !== 1'b0 || checksum_err !== 1'b0)
            begin bad++; $display("FAIL csum_good: got ok=%b done=%b proc_reset=%b err=%b want 1 1 0 0", ok, ld, lp, checksum_err); end
        prog_q = '{$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        load_program(1'b0, 1, 1'b1, ok, sb, sp, lw, la, ld, lp);
        total++; if (!ok || checksum_err !== 1'b1) begin bad++; $display("FAIL csum_bad_err: got ok=%b err=%b want 1 1", ok, checksum_err); end
        total++; if (done_cnt != d0 || proc_reset !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL csum_bad_state: got dones=%0d proc_reset=%b busy=%b want 0 1 0", done_cnt - d0, proc_reset, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_partial();
        test_random_gaps();
        test_start_mid();
        test_reset_mid();
        test_overflow();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
